cpuregs_rdport: RTL and testbench
=================================

# cpuregs_rdport

Read side of the CPU register file. It holds the 32-bit register array, which is filled through a write strobe driven by the core's register writeback. It serves two-operand (rs1/rs2) read requests over a valid/ready handshake and returns both operands together on a registered response channel. In single-port builds it serialises the two reads over two cycles. Sits between the decode stage, which issues requests, and the ALU operand latch, which consumes responses.

## Interface
Parameters:
- ENABLE_REGS_16_31, 1: 1 gives 32 registers and a 5-bit index; 0 gives 16 registers and a 4-bit index (RB = 5 or 4).
- ENABLE_REGS_DUALPORT, 1: 1 reads rs1 and rs2 in the same cycle; 0 uses a single array read port and a 2-cycle read.
- REGS_INIT_ZERO, 0: 1 zero-initialises the array at time 0 via an initial block. It is not a reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe from writeback.
- wr_idx  in  RB  write index; index 0 is ignored.
- wr_data  in  32  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  block can accept a request.
- rs1  in  RB  first operand index.
- rs2  in  RB  second operand index.
- rsp_valid  out  1  operand pair valid.
- rsp_ready  in  1  consumer accepts the pair.
- rs1_data  out  32  rs1 operand.
- rs2_data  out  32  rs2 operand.

## Operation
- Write: on a clock edge with wr_en=1 and wr_idx!=0, the array entry wr_idx takes wr_data. Writes to index 0 are dropped.
- Reads of index 0 always return 32'h0, regardless of the array contents or any bypass.
- A request is accepted in a cycle where rd_valid && rd_ready. The rs1/rs2 indices are latched on acceptance.
- FSM states:
  - IDLE: no response pending.
  - READ2: single-port only; the rs1 result is held and rs2 is being read.
  - RESP: rsp_valid=1.
- Dual-port transitions: IDLE -> RESP on accept. RESP -> IDLE on rsp_ready with no new accept. RESP -> RESP on rsp_ready together with a new accept.
- Single-port transitions: IDLE -> READ2 on accept. READ2 -> RESP unconditionally. RESP -> IDLE on rsp_ready. There are no back-to-back accepts in single-port mode.
- rd_ready:
  - Dual-port: (state==IDLE) || (state==RESP && rsp_ready).
  - Single-port: state==IDLE.
- Response data is a snapshot. While RESP is held with rsp_ready=0, rs1_data and rs2_data stay stable even if a write hits rs1 or rs2.
- Array reads are combinational from the latched or incoming index. The result is captured into the output registers.

## Timing
- Reset values: rsp_valid=0, rs1_data=0, rs2_data=0, rd_ready=1, state=IDLE. The array contents are not reset.
- Reset asserted mid-operation: any pending or in-flight response is discarded. rsp_valid drops asynchronously.
- Dual-port latency: accept in cycle N gives rsp_valid in N+1. Sustained throughput is 1 request per cycle while rsp_ready=1.
- Single-port latency:
  - rs1 is read in cycle N (the accept cycle).
  - rs2 is read in cycle N+1 (READ2).
  - rsp_valid is high in N+2.
  - Throughput is 1 request per 3 cycles when rsp_ready is held at 1.
- A write in cycle M is visible to array reads in cycle M+1 and later.
- A same-cycle write and read of the same nonzero index is governed by the configuration macro below.

## Configuration
- CPUREGS_RDPORT_BYPASS_EN defined:
  - A read performed in the same cycle as wr_en=1 with a matching nonzero wr_idx returns wr_data.
  - This applies per operand and per read cycle: cycle N for both operands in dual-port mode; cycle N for rs1 and N+1 for rs2 in single-port mode.
- Undefined: that same-cycle read returns the old array value. Software or the pipeline must stall one cycle to observe the write.

## Test plan
- Reset, then write x5=32'hDEADBEEF and x6=32'h12345678, then request rs1=5, rs2=6. Expect rsp_valid one cycle after accept (dual-port) with rs1_data=DEADBEEF and rs2_data=12345678.
- Write x0=32'hFFFFFFFF, then request rs1=0, rs2=0. Expect both outputs 0, including the cycle where the write is concurrent.
- With the array holding x3=1, write x3=32'hA5A5A5A5 in the same cycle as a request for rs1=3:
  - Bypass macro defined: rs1_data=A5A5A5A5.
  - Bypass macro undefined: rs1_data=1.
- Hold rsp_ready=0 for 4 cycles with x7 in the response, and write x7=32'h0BAD in between. Expect rs1_data unchanged, rd_ready=0 throughout, and a 3-cycle stream afterwards.
- Build with ENABLE_REGS_DUALPORT=0 and issue 3 requests with rsp_ready=1. Expect rsp_valid at N+2, N+5 and N+8, and rd_ready low in READ2 and RESP.
- Assert reset while in READ2 (single-port) or RESP. Expect rsp_valid=0 immediately, and no response after reset is released.

Source files
------------

// File: rtl/cpuregs_rdport_if.sv
`default_nettype none
// ============================================================================
// cpuregs_rdport_if : write strobe, operand read request and response bundle
// Rev 1.0
// ============================================================================
interface cpuregs_rdport_if #(
    parameter int RB = 5
);
    logic          wr_en;
    logic [RB-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [RB-1:0] rs1;
    logic [RB-1:0] rs2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;

    // Decode / writeback side
    modport master (
        output wr_en, wr_idx, wr_data, rd_valid, rs1, rs2, rsp_ready,
        input  rd_ready, rsp_valid, rs1_data, rs2_data
    );

    // Register file side
    modport slave (
        input  wr_en, wr_idx, wr_data, rd_valid, rs1, rs2, rsp_ready,
        output rd_ready, rsp_valid, rs1_data, rs2_data
    );
endinterface
`default_nettype wire

// File: rtl/cpuregs_rdport.sv
`default_nettype none
// ============================================================================
// cpuregs_rdport : register array with a valid/ready rs1/rs2 read port.
// Same-cycle write-to-read bypass enabled by CPUREGS_RDPORT_BYPASS_EN.
// Rev 1.0
// ============================================================================
module cpuregs_rdport #(
    parameter int ENABLE_REGS_16_31    = 1,
    parameter int ENABLE_REGS_DUALPORT = 1,
    parameter int REGS_INIT_ZERO       = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    cpuregs_rdport_if.slave bus
);
    localparam int c_RB    = (ENABLE_REGS_16_31 != 0) ? 5 : 4;
    localparam int c_NREGS = 1 << c_RB;
`ifdef CPUREGS_RDPORT_BYPASS_EN
    localparam logic c_BYPASS = 1'b1;
`else
    localparam logic c_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ2 = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_rsp_valid;
    logic [31:0]       r_rs1_data;
    logic [31:0]       r_rs2_data;
    logic [c_RB-1:0]   r_rs2_idx;

    logic              w_rd_ready;
    logic              w_accept;
    logic [c_RB-1:0]   w_idx_a;
    logic [c_RB-1:0]   w_idx_b;
    logic [31:0]       w_arr_a;
    logic [31:0]       w_arr_b;
    logic [31:0]       w_data_a;
    logic [31:0]       w_data_b;

    // Port A serves rs1, and in single-port builds also the latched rs2 in READ2
    assign w_idx_a  = (r_state == S_READ2) ? r_rs2_idx : bus.rs1;
    assign w_idx_b  = bus.rs2;
    assign w_accept = bus.rd_valid && w_rd_ready;

    always_comb begin
        w_rd_ready = (r_state == S_IDLE);
        if (ENABLE_REGS_DUALPORT != 0) begin
            w_rd_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready);
        end
    end

    generate
        if (REGS_INIT_ZERO != 0) begin : g_mem_zero
            logic [31:0] r_regs [c_NREGS] = '{default: '0};
            always_ff @(posedge clk) begin
                if (bus.wr_en && (bus.wr_idx != '0)) begin
                    r_regs[bus.wr_idx] <= bus.wr_data;
                end
            end
            assign w_arr_a = r_regs[w_idx_a];
            assign w_arr_b = r_regs[w_idx_b];
        end else begin : g_mem_plain
            logic [31:0] r_regs [c_NREGS];
            always_ff @(posedge clk) begin
                if (bus.wr_en && (bus.wr_idx != '0)) begin
                    r_regs[bus.wr_idx] <= bus.wr_data;
                end
            end
            assign w_arr_a = r_regs[w_idx_a];
            assign w_arr_b = r_regs[w_idx_b];
        end
    endgenerate

    // x0 override is applied last so it also masks a bypassed write to index 0
    always_comb begin
        w_data_a = w_arr_a;
        if (c_BYPASS && bus.wr_en && (bus.wr_idx == w_idx_a)) begin
            w_data_a = bus.wr_data;
        end
        if (w_idx_a == '0) begin
            w_data_a = '0;
        end
    end

    always_comb begin
        w_data_b = w_arr_b;
        if (c_BYPASS && bus.wr_en && (bus.wr_idx == w_idx_b)) begin
            w_data_b = bus.wr_data;
        end
        if (w_idx_b == '0) begin
            w_data_b = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rs2_idx   <= '0;
        end else if (ENABLE_REGS_DUALPORT != 0) begin
            if (w_accept) begin
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
                r_rs1_data  <= w_data_a;
                r_rs2_data  <= w_data_b;
            end else if ((r_state != S_RESP) || bus.rsp_ready) begin
                r_state     <= S_IDLE;
                r_rsp_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_READ2;
                        r_rs1_data <= w_data_a;
                        r_rs2_idx  <= bus.rs2;
                    end
                end
                S_READ2: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rs2_data  <= w_data_a;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_ready  = w_rd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rs1_data  = r_rs1_data;
    assign bus.rs2_data  = r_rs2_data;
endmodule
`default_nettype wire

// File: tb/tb_cpuregs_rdport.sv
`default_nettype none
// ============================================================================
// tb_cpuregs_rdport : dual- and single-port instances driven side by side
// against a behavioural register-file model.  Rev 1.0
// ============================================================================
module tb_cpuregs_rdport;
`ifdef CPUREGS_RDPORT_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rsp_ready;

    always #5 clk = ~clk;

    cpuregs_rdport_if #(.RB(5)) ifd ();
    cpuregs_rdport_if #(.RB(5)) ifs ();

    assign ifd.wr_en = wr_en;     assign ifs.wr_en = wr_en;
    assign ifd.wr_idx = wr_idx;   assign ifs.wr_idx = wr_idx;
    assign ifd.wr_data = wr_data; assign ifs.wr_data = wr_data;
    assign ifd.rd_valid = rd_valid; assign ifs.rd_valid = rd_valid;
    assign ifd.rs1 = rs1;         assign ifs.rs1 = rs1;
    assign ifd.rs2 = rs2;         assign ifs.rs2 = rs2;
    assign ifd.rsp_ready = rsp_ready; assign ifs.rsp_ready = rsp_ready;

    cpuregs_rdport #(.ENABLE_REGS_16_31(1), .ENABLE_REGS_DUALPORT(1), .REGS_INIT_ZERO(0))
        u_dual (.clk(clk), .reset(reset), .bus(ifd));
    cpuregs_rdport #(.ENABLE_REGS_16_31(1), .ENABLE_REGS_DUALPORT(0), .REGS_INIT_ZERO(0))
        u_single (.clk(clk), .reset(reset), .bus(ifs));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural register contents plus one outstanding response per DUT
    logic [31:0] mem [32];
    logic        d_valid;
    logic [31:0] d_r1, d_r2;
    int          s_age;          // -1 none, 0 = rs2 still to read, >=1 = response presented
    logic [31:0] s_r1, s_r2;
    logic [4:0]  s_rs2;

    typedef struct packed {
        logic        we;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rv(input logic [4:0] i);
        if (i == 5'd0) return 32'h0;
        if (c_BYP && wr_en && (wr_idx == i)) return wr_data;
        return mem[i];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                         input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic rr);
        wr_en = we; wr_idx = wi; wr_data = wd;
        rd_valid = v; rs1 = a; rs2 = b; rsp_ready = rr;
    endtask

    // Called at a falling edge with this cycle's inputs already driven
    task automatic step();
        logic d_rdy;
        logic s_rdy;
        #1;
        d_rdy = !d_valid || rsp_ready;
        s_rdy = (s_age < 0);
        chk("dual rd_ready", 32'(ifd.rd_ready), 32'(d_rdy));
        chk("dual rsp_valid", 32'(ifd.rsp_valid), 32'(d_valid));
        if (d_valid) begin
            chk("dual rs1_data", ifd.rs1_data, d_r1);
            chk("dual rs2_data", ifd.rs2_data, d_r2);
        end
        chk("sp rd_ready", 32'(ifs.rd_ready), 32'(s_rdy));
        chk("sp rsp_valid", 32'(ifs.rsp_valid), 32'(s_age >= 1));
        if (s_age >= 1) begin
            chk("sp rs1_data", ifs.rs1_data, s_r1);
            chk("sp rs2_data", ifs.rs2_data, s_r2);
        end
        if (d_valid && rsp_ready) d_valid = 1'b0;
        if (rd_valid && d_rdy) begin
            d_valid = 1'b1;
            d_r1 = rv(rs1);
            d_r2 = rv(rs2);
        end
        if (s_age == 0) begin
            s_r2  = rv(s_rs2);
            s_age = 1;
        end else if (s_age >= 1) begin
            if (rsp_ready) s_age = -1;
        end else if (rd_valid) begin
            s_r1  = rv(rs1);
            s_rs2 = rs2;
            s_age = 0;
        end
        if (wr_en && (wr_idx != 5'd0)) mem[wr_idx] = wr_data;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        d_valid = 1'b0;
        s_age   = -1;
        reset   = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("reset dual rsp_valid", 32'(ifd.rsp_valid), 32'h0);
        chk("reset dual rd_ready", 32'(ifd.rd_ready), 32'h1);
        chk("reset dual rs1_data", ifd.rs1_data, 32'h0);
        chk("reset dual rs2_data", ifd.rs2_data, 32'h0);
        chk("reset sp rsp_valid", 32'(ifs.rsp_valid), 32'h0);
        chk("reset sp rd_ready", 32'(ifs.rd_ready), 32'h1);
        chk("reset sp rs1_data", ifs.rs1_data, 32'h0);
        chk("reset sp rs2_data", ifs.rs2_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), (i == 3) ? 32'h1 : (32'h1000_0000 + 32'(i)),
                  1'b0, 5'd0, 5'd0, 1'b1);
            step();
        end

        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 5'd6, 32'h12345678, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h12345678};
        tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd6,
                   c_BYP ? 32'hA5A5A5A5 : 32'h1, 32'h12345678};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[6] = '{1'b1, 5'd6, 32'h42, 5'd6, 5'd5,
                   c_BYP ? 32'h42 : 32'h12345678, 32'hDEADBEEF};
        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].we, tbl[k].wi, tbl[k].wd, 1'b1, tbl[k].r1, tbl[k].r2, 1'b1);
            step();
            chk("tbl dual valid", 32'(ifd.rsp_valid), 32'h1);
            chk("tbl dual rs1", ifd.rs1_data, tbl[k].e1);
            chk("tbl dual rs2", ifd.rs2_data, tbl[k].e2);
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
            step();
            chk("tbl sp valid", 32'(ifs.rsp_valid), 32'h1);
            chk("tbl sp rs1", ifs.rs1_data, tbl[k].e1);
            chk("tbl sp rs2", ifs.rs2_data, tbl[k].e2);
            step();
        end

        // Response snapshot held under backpressure while x7 is overwritten
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b1);
        step();
        for (int h = 0; h < 4; h++) begin
            drive(h == 1, 5'd7, 32'h0BAD, 1'b1, 5'd7, 5'd7, 1'b0);
            step();
            chk("hold dual rs1", ifd.rs1_data, 32'h1000_0007);
            chk("hold dual rd_ready", 32'(ifd.rd_ready), 32'h0);
        end
        chk("hold sp rs2", ifs.rs2_data, 32'h1000_0007);
        for (int h = 0; h < 3; h++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5, 1'b1);
            step();
            chk("stream dual valid", 32'(ifd.rsp_valid), 32'h1);
        end
        chk("stream dual rs1", ifd.rs1_data, 32'h0BAD);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        repeat (3) step();

        // Single-port cadence: three back-to-back requests
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 5'd0, 32'h0, k < 9, 5'(k + 1), 5'(k + 2), 1'b1);
            #1;
            chk("sp cadence valid", 32'(ifs.rsp_valid), 32'(k == 2 || k == 5 || k == 8));
            chk("sp cadence ready", 32'(ifs.rd_ready), 32'(k == 0 || k == 3 || k == 6 || k == 9));
            step();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        repeat (3) step();

        // Reset while dual is in RESP and single is in READ2
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6, 1'b0);
        step();
        reset = 1'b1;
        #1;
        chk("midreset dual rsp_valid", 32'(ifd.rsp_valid), 32'h0);
        chk("midreset sp rsp_valid", 32'(ifs.rsp_valid), 32'h0);
        chk("midreset dual rd_ready", 32'(ifd.rd_ready), 32'h1);
        d_valid = 1'b0;
        s_age   = -1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("postreset sp rsp_valid", 32'(ifs.rsp_valid), 32'h0);
        end

        for (int k = 0; k < 400; k++) begin
            logic [4:0] wi;
            wi = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 1) == 1, wi, $urandom,
                  $urandom_range(0, 9) < 6,
                  ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 7);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
